mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// MemPortArbiter (module mem_port_arbiter)
//
// Round-robin arbiter that shares one single-port memory bank between
// NUM_PORTS clients. A grant is made combinationally in IDLE and beat 0
// goes to the bank in that same cycle. A full-width access then spends one
// BEAT1 cycle on addr+1 with the high data word. Read tags travel through a
// READ_LATENCY-deep pipeline so that each returning bank word can be steered
// to the port that asked for it. Responses are registered.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_en/wr/width     per-port request, direction, half(0)/full(1) width
//   req_addr, req_wdata per-port word address and 2-word write data
//   req_ready           one-hot grant pulse
//   rsp_valid, rsp_data per-port read response pulse and data
//   bank_en, bank_chip_en, bank_addr, bank_wdata, bank_rdata
//                       memory bank strobe, write enable, address, data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_en,
  input  logic [NUM_PORTS-1:0]          req_wr,
  input  logic [NUM_PORTS-1:0]          req_width,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*2*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [NUM_PORTS*2*DATA_W-1:0] rsp_data,
  output logic                          bank_en,
  output logic                          bank_chip_en,
  output logic [ADDR_W-1:0]             bank_addr,
  output logic [DATA_W-1:0]             bank_wdata,
  input  logic [DATA_W-1:0]             bank_rdata
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HEAD = READ_LATENCY - 1;

  typedef enum logic {IDLE, BEAT1} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rrPtr_q, rrPtr_d;
  logic [PW-1:0]           latPort_q;
  logic                    latWr_q;
  logic [ADDR_W-1:0]       latAddr_q;
  logic [DATA_W-1:0]       latWdataHi_q;

  logic [READ_LATENCY-1:0] tagValid_q;
  logic [READ_LATENCY-1:0] tagFull_q;
  logic [READ_LATENCY-1:0] tagBeat_q;
  logic [PW-1:0]           tagPort_q [READ_LATENCY];

  logic [DATA_W-1:0]           word0_q;
  logic [NUM_PORTS-1:0]        rspValid_q;
  logic [NUM_PORTS*2*DATA_W-1:0] rspData_q;

  logic          grantValid;
  logic [PW-1:0] grantIdx;
  logic [PW:0]   cand;
  logic [PW:0]   nextPtr;
  logic          issueRead;
  logic [PW-1:0] issuePort;
  logic          issueFull;
  logic          issueBeat;

  // Round-robin search: first requesting port at or after rrPtr_q.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rrPtr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!grantValid && req_en[cand[PW-1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = cand[PW-1:0];
      end
    end
  end

  // Next-state and bank drive. Everything is gated by rst_n so that the
  // combinational outputs also drop to zero the instant reset asserts.
  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    req_ready    = '0;
    bank_en      = 1'b0;
    bank_chip_en = 1'b0;
    bank_addr    = '0;
    bank_wdata   = '0;
    nextPtr      = {1'b0, grantIdx} + (PW+1)'(1);
    if (nextPtr >= (PW+1)'(NUM_PORTS)) nextPtr = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            req_ready[grantIdx] = 1'b1;
            bank_en      = 1'b1;
            bank_chip_en = req_wr[grantIdx];
            bank_addr    = req_addr[grantIdx*ADDR_W +: ADDR_W];
            bank_wdata   = req_wdata[grantIdx*2*DATA_W +: DATA_W];
            rrPtr_d      = nextPtr[PW-1:0];
            if (req_width[grantIdx]) state_d = BEAT1;
          end
        end
        BEAT1: begin
          bank_en      = 1'b1;
          bank_chip_en = latWr_q;
          bank_addr    = latAddr_q + ADDR_W'(1);
          bank_wdata   = latWdataHi_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Tag describing the read (if any) that hits the bank this cycle.
  always_comb begin
    issueRead = bank_en && !bank_chip_en;
    issuePort = (state_q == BEAT1) ? latPort_q : grantIdx;
    issueFull = (state_q == BEAT1) ? 1'b1 : req_width[grantIdx];
    issueBeat = (state_q == BEAT1);
  end

  // FSM, round-robin pointer and beat-1 latch. The request is captured at
  // the grant so the client may drop or change req_* right afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      latPort_q    <= '0;
      latWr_q      <= 1'b0;
      latAddr_q    <= '0;
      latWdataHi_q <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      if (state_q == IDLE && grantValid) begin
        latPort_q    <= grantIdx;
        latWr_q      <= req_wr[grantIdx];
        latAddr_q    <= req_addr[grantIdx*ADDR_W +: ADDR_W];
        latWdataHi_q <= req_wdata[grantIdx*2*DATA_W + DATA_W +: DATA_W];
      end
    end
  end

  // Tag pipeline: the entry at HEAD lines up with bank_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagValid_q <= '0;
      tagFull_q  <= '0;
      tagBeat_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tagPort_q[i] <= '0;
    end else begin
      tagValid_q[0] <= issueRead;
      tagFull_q[0]  <= issueFull;
      tagBeat_q[0]  <= issueBeat;
      tagPort_q[0]  <= issuePort;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagFull_q[i]  <= tagFull_q[i-1];
        tagBeat_q[i]  <= tagBeat_q[i-1];
        tagPort_q[i]  <= tagPort_q[i-1];
      end
    end
  end

  // Response capture. Beat 0 of a full read parks in word0_q; beats of one
  // full read are always adjacent, so a single holding register suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0_q    <= '0;
      rspValid_q <= '0;
      rspData_q  <= '0;
    end else begin
      rspValid_q <= '0;
      if (tagValid_q[HEAD]) begin
        if (!tagFull_q[HEAD]) begin
          rspValid_q[tagPort_q[HEAD]] <= 1'b1;
          rspData_q[tagPort_q[HEAD]*2*DATA_W +: 2*DATA_W] <= {{DATA_W{1'b0}}, bank_rdata};
        end else if (!tagBeat_q[HEAD]) begin
          word0_q <= bank_rdata;
        end else begin
          rspValid_q[tagPort_q[HEAD]] <= 1'b1;
          rspData_q[tagPort_q[HEAD]*2*DATA_W +: 2*DATA_W] <= {bank_rdata, word0_q};
        end
      end
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (4 ports, 16-bit words, 14-bit
// addresses, read latency 2) with a behavioural bank. Expected read
// responses and bank writes are queued when a grant is expected and checked
// by a negedge monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int RL = 2;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     reqEn, reqWr, reqWidth;
  logic [NP*AW-1:0]  reqAddr;
  logic [NP*32-1:0]  reqWdata;
  logic [NP-1:0]     req_ready, rsp_valid;
  logic [NP*32-1:0]  rsp_data;
  logic              bank_en, bank_chip_en;
  logic [AW-1:0]     bank_addr;
  logic [DW-1:0]     bank_wdata, bank_rdata;

  logic [15:0] mem [16384];
  logic [15:0] rdPipe [RL];

  rsp_t rspQ[$];
  wr_t  wrQ[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;

  mem_port_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_en(reqEn), .req_wr(reqWr), .req_width(reqWidth),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_en(bank_en), .bank_chip_en(bank_chip_en),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: write at the strobe edge, read data valid RL cycles
  // after the strobe cycle.
  always @(posedge clk) begin
    if (bank_en && bank_chip_en) mem[bank_addr] <= bank_wdata;
    rdPipe[0] <= (bank_en && !bank_chip_en) ? mem[bank_addr] : 16'h0000;
    for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign bank_rdata = rdPipe[RL-1];

  function automatic logic [15:0] patt(logic [13:0] a);
    return (a == 14'h0010) ? 16'h1234 : ({2'b00, a} ^ 16'hA500);
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(int port, bit en, bit wr, bit full,
                               logic [13:0] addr, logic [31:0] wdata);
    reqEn[port]    = en;
    reqWr[port]    = wr;
    reqWidth[port] = full;
    reqAddr[port*AW +: AW]  = addr;
    reqWdata[port*32 +: 32] = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Check the grant this cycle against the intended port and queue what
  // that access should later produce.
  task automatic expectGrant(string tag, int port, bit wr, bit full,
                             logic [13:0] addr, logic [31:0] wdata);
    logic [13:0] a1;
    logic [3:0]  oneHot;
    rsp_t r;
    wr_t  w;
    a1 = addr + 14'd1;
    oneHot = 4'b0001 << port;
    checkOutput(tag, 64'(req_ready), 64'(oneHot));
    if (wr) begin
      w.addr = addr; w.data = wdata[15:0]; w.cyc = cyc;
      wrQ.push_back(w);
      if (full) begin
        w.addr = a1; w.data = wdata[31:16]; w.cyc = cyc + 1;
        wrQ.push_back(w);
      end
    end else begin
      r.port = port;
      r.data = full ? {patt(a1), patt(addr)} : {16'h0000, patt(addr)};
      r.cyc  = cyc + (full ? RL + 2 : RL + 1);
      rspQ.push_back(r);
    end
  endtask

  // Scoreboard monitor: every rsp_valid and every bank write must match the
  // oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    for (int p = 0; p < NP; p++) begin
      if (rsp_valid[p] === 1'b1) begin
        if (rspQ.size() == 0) begin
          checkOutput("rsp_unexpected_port", 64'(p), 64'hFF);
        end else begin
          e = rspQ.pop_front();
          checkOutput("rsp_port", 64'(p), 64'(e.port));
          checkOutput("rsp_data", 64'(rsp_data[p*32 +: 32]), 64'(e.data));
          checkOutput("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
    if (bank_en === 1'b1 && bank_chip_en === 1'b1) begin
      if (wrQ.size() == 0) begin
        checkOutput("wr_unexpected_addr", 64'(bank_addr), 64'hFFFFF);
      end else begin
        w = wrQ.pop_front();
        checkOutput("wr_addr", 64'(bank_addr), 64'(w.addr));
        checkOutput("wr_data", 64'(bank_wdata), 64'(w.data));
        checkOutput("wr_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    reqEn    = '1;
    reqWr    = '0;
    reqWidth = '0;
    reqAddr  = '0;
    reqWdata = '0;
    for (int i = 0; i < RL; i++) rdPipe[i] = 16'h0000;
    for (int i = 0; i < 16384; i++) mem[i] = patt(14'(i));

    // Reset with all requests raised: every output must stay zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_bank_en", 64'(bank_en), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'h0);
    nextCycle();
    reqEn = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_bank_zero",
                64'({bank_en, bank_chip_en, bank_addr, bank_wdata}), 64'h0);

    // Port 2 half read of 0x0010 -> 0x0000_1234 three cycles later.
    nextCycle();
    applyStimulus(2, 1, 0, 0, 14'h0010, 32'h0);
    @(negedge clk);
    expectGrant("A_grant", 2, 0, 0, 14'h0010, 32'h0);
    checkOutput("A_bank_addr", 64'(bank_addr), 64'h10);
    checkOutput("A_bank_rd", 64'({bank_en, bank_chip_en}), 64'b10);
    nextCycle();
    applyStimulus(2, 0, 0, 0, 14'h0, 32'h0);
    repeat (5) nextCycle();

    // Port 0 full write wrapping 0x3FFF -> 0x0000.
    applyStimulus(0, 1, 1, 1, 14'h3FFF, 32'hBEEF_CAFE);
    @(negedge clk);
    expectGrant("B_grant", 0, 1, 1, 14'h3FFF, 32'hBEEF_CAFE);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 14'h0, 32'h0);
    @(negedge clk);
    checkOutput("B_beat1_ready", 64'(req_ready), 64'h0);
    checkOutput("B_beat1_addr", 64'(bank_addr), 64'h0);
    repeat (4) nextCycle();

    // Port 1 full read with port 3 half read pending behind it.
    applyStimulus(1, 1, 0, 1, 14'h0100, 32'h0);
    applyStimulus(3, 1, 0, 0, 14'h0200, 32'h0);
    @(negedge clk);
    expectGrant("C_grant_p1", 1, 0, 1, 14'h0100, 32'h0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 14'h0, 32'h0);
    @(negedge clk);
    checkOutput("C_beat1_ready", 64'(req_ready), 64'h0);
    checkOutput("C_beat1_addr", 64'(bank_addr), 64'h101);
    nextCycle();
    @(negedge clk);
    expectGrant("C_grant_p3", 3, 0, 0, 14'h0200, 32'h0);
    nextCycle();
    applyStimulus(3, 0, 0, 0, 14'h0, 32'h0);
    repeat (5) nextCycle();

    // All four ports stream half reads: grants rotate 0,1,2,3,0,...
    for (int p = 0; p < NP; p++) applyStimulus(p, 1, 0, 0, 14'(14'h0020 + p), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      expectGrant("D_rr_grant", k % NP, 0, 0, 14'(14'h0020 + (k % NP)), 32'h0);
      nextCycle();
    end
    reqEn = '0;
    repeat (5) nextCycle();

    // Port 2 gives up while port 0 owns the bank for a full write.
    applyStimulus(0, 1, 1, 1, 14'h0400, 32'h1111_2222);
    applyStimulus(2, 1, 0, 0, 14'h0300, 32'h0);
    @(negedge clk);
    expectGrant("E_grant_p0", 0, 1, 1, 14'h0400, 32'h1111_2222);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 14'h0, 32'h0);
    applyStimulus(2, 0, 0, 0, 14'h0, 32'h0);
    @(negedge clk);
    checkOutput("E_beat1_ready", 64'(req_ready), 64'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("E_no_port2", 64'({req_ready, bank_en}), 64'h0);
    repeat (4) nextCycle();

    // Reset in the beat-1 cycle of a full read: nothing may follow.
    applyStimulus(1, 1, 0, 1, 14'h0500, 32'h0);
    @(negedge clk);
    checkOutput("F_grant_p1", 64'(req_ready), 64'b0010);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 14'h0, 32'h0);
    @(negedge clk);
    checkOutput("F_rst_bank_en", 64'(bank_en), 64'h0);
    checkOutput("F_rst_ready", 64'(req_ready), 64'h0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    repeat (6) nextCycle();

    // Pointer back at 0: port 0 wins over port 3, then port 3 follows.
    applyStimulus(0, 1, 0, 0, 14'h0600, 32'h0);
    applyStimulus(3, 1, 0, 0, 14'h0601, 32'h0);
    @(negedge clk);
    expectGrant("F_ptr_reset", 0, 0, 0, 14'h0600, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 14'h0, 32'h0);
    @(negedge clk);
    expectGrant("F_next_p3", 3, 0, 0, 14'h0601, 32'h0);
    nextCycle();
    applyStimulus(3, 0, 0, 0, 14'h0, 32'h0);
    repeat (6) nextCycle();

    checkOutput("sb_rsp_drained", 64'(rspQ.size()), 64'h0);
    checkOutput("sb_wr_drained", 64'(wrQ.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
